// File: rtl/mips_cpu_alu_arbiter.sv
// mips_cpu_alu_arbiter: round-robin share of one combinational ALU between two requesters
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   reqN_valid_i/ready_o    : request handshake for requester N (0 = execute, 1 = branch/addr)
//   reqN_op_i/a_i/b_i/sa_i  : operation fields, sampled only at the accepting edge
//   rsp_valid_o/ready_i     : response handshake; rsp_id/result/zero/err held until accepted
//   alu_*_o / alu_*_i       : external ALU port, driven with live operands only in EXEC
module mips_cpu_alu_arbiter #(
    parameter int NUM_OPS    = 12,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [4:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [4:0]  req0_sa_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [4:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic [4:0]  req1_sa_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic        rsp_err_o,
    output logic [4:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_sa_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state_q, state_d;
    logic        prio_q, id_q, rsp_id_q, rsp_zero_q, rsp_err_q;
    logic [4:0]  op_q, sa_q;
    logic [31:0] a_q, b_q, rsp_result_q;
    logic        idle, gnt0, gnt1, hs, illegal;
    logic [4:0]  sel_op;
    // readies are forced low while reset is held even though the state reads IDLE
    assign idle    = (state_q == IDLE) && !reset_i;
    assign gnt0    = idle && req0_valid_i && (!req1_valid_i || !prio_q);
    assign gnt1    = idle && req1_valid_i && (!req0_valid_i || prio_q);
    assign hs      = gnt0 || gnt1;
    assign sel_op  = gnt1 ? req1_op_i : req0_op_i;
    assign illegal = {27'd0, sel_op} >= 32'(NUM_OPS);
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign rsp_valid_o  = state_q == RESP;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_err_o    = rsp_err_q;
    always_comb begin
        state_d  = state_q;
        alu_op_o = '0;
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_sa_o = '0;
        case (state_q)
            IDLE: state_d = hs ? (illegal ? RESP : EXEC) : IDLE;
            EXEC: begin
                state_d  = RESP;
                alu_op_o = op_q;
                alu_a_o  = a_q;
                alu_b_o  = b_q;
                alu_sa_o = sa_q;
            end
            RESP: state_d = rsp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            prio_q       <= RESET_PRIO;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sa_q         <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                op_q   <= sel_op;
                a_q    <= gnt1 ? req1_a_i : req0_a_i;
                b_q    <= gnt1 ? req1_b_i : req0_b_i;
                sa_q   <= gnt1 ? req1_sa_i : req0_sa_i;
                id_q   <= gnt1;
                prio_q <= !gnt1;
                // illegal ops bypass EXEC, so the response is formed right here
                if (illegal) begin
                    rsp_id_q     <= gnt1;
                    rsp_result_q <= '0;
                    rsp_zero_q   <= 1'b0;
                    rsp_err_q    <= 1'b1;
                end
            end
            if (state_q == EXEC) begin
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_result_i;
                rsp_zero_q   <= alu_zero_i;
                rsp_err_q    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_alu_arbiter.sv
// tb_mips_cpu_alu_arbiter: table, directed and randomized checks of the ALU arbiter
module tb_mips_cpu_alu_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
    logic [4:0]  req0_op = 0, req0_sa = 0, req1_op = 0, req1_sa = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp_valid, rsp_ready = 1, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_result;
    logic [4:0]  alu_op, alu_sa;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mips_cpu_alu_arbiter #(.NUM_OPS(12), .RESET_PRIO(1'b0)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_sa_i(req0_sa),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_sa_i(req1_sa),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sa_o(alu_sa),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero)
    );

    // stand-in for the shared MIPS ALU
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
        case (op)
            5'd0:    return a & b;
            5'd1:    return a | b;
            5'd2:    return a + b;
            5'd3:    return a - b;
            5'd4:    return {31'd0, $signed(a) < $signed(b)};
            5'd5:    return b << sa;
            5'd6:    return b >> sa;
            5'd7:    return 32'($signed(b) >>> sa);
            5'd8:    return a ^ b;
            5'd9:    return ~(a | b);
            5'd10:   return {b[15:0], 16'd0};
            5'd11:   return {31'd0, a < b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b, alu_sa);
    assign alu_zero = alu_result == 32'd0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        req0_valid = 1;
        req1_valid = 1;
        #1;
        chk("rst ready0", req0_ready, 0);
        chk("rst ready1", req1_ready, 0);
        chk("rst valid", rsp_valid, 0);
        chk("rst id", rsp_id, 0);
        chk("rst result", rsp_result, 0);
        chk("rst zero", rsp_zero, 0);
        chk("rst err", rsp_err, 0);
        chk("rst alu_op", alu_op, 0);
        chk("rst alu_a", alu_a, 0);
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    // one accepted operation with fixed latency: handshake, (EXEC), RESP with optional stall
    task automatic run_txn(input string n, input logic v0, input logic v1,
                           input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] sa0,
                           input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] sa1,
                           input int stall, input logic eid, input logic [31:0] eres, input logic ez, input logic ee);
        logic [4:0]  wop, wsa;
        logic [31:0] wa, wb;
        wop = eid ? op1 : op0;
        wa  = eid ? a1 : a0;
        wb  = eid ? b1 : b0;
        wsa = eid ? sa1 : sa0;
        @(posedge clk); #1;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_sa = sa0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_sa = sa1;
        rsp_ready = stall == 0;
        #1;
        chk({n, " ready0"}, req0_ready, !eid);
        chk({n, " ready1"}, req1_ready, eid);
        chk({n, " idle alu_op"}, alu_op, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        req0_a = $urandom; req1_a = $urandom; req0_op = 5'd2; req1_op = 5'd2;
        if (!ee) begin
            chk({n, " exec valid"}, rsp_valid, 0);
            chk({n, " exec alu_op"}, alu_op, wop);
            chk({n, " exec alu_a"}, alu_a, wa);
            chk({n, " exec alu_b"}, alu_b, wb);
            chk({n, " exec alu_sa"}, alu_sa, wsa);
            @(posedge clk); #1;
        end
        chk({n, " valid"}, rsp_valid, 1);
        chk({n, " id"}, rsp_id, eid);
        chk({n, " result"}, rsp_result, eres);
        chk({n, " zero"}, rsp_zero, ez);
        chk({n, " err"}, rsp_err, ee);
        chk({n, " resp alu_a"}, alu_a, 0);
        chk({n, " resp alu_op"}, alu_op, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({n, " stall valid"}, rsp_valid, 1);
            chk({n, " stall result"}, rsp_result, eres);
            chk({n, " stall id"}, rsp_id, eid);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk({n, " drop valid"}, rsp_valid, 0);
    endtask

    typedef struct {
        logic        id;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sa;
        logic [31:0] res;
        logic        zero, err;
        int          stall;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int   grants[$];
        int   rsp_ids[$];
        int   seen;
        logic prio_m, v0, v1, eid, ee;
        logic [4:0]  o0, o1, s0, s1, wop;
        logic [31:0] x0, y0, x1, y1, eres;
        int   r;
        tbl[0] = '{1'b0, 5'd2,  32'd5,        32'd7,        5'd0, 32'd12,        1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 5'd3,  32'd9,        32'd9,        5'd0, 32'd0,         1'b1, 1'b0, 1};
        tbl[2] = '{1'b0, 5'd12, 32'd1,        32'd2,        5'd3, 32'd0,         1'b0, 1'b1, 2};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,         1'b0, 1'b1, 0};
        tbl[4] = '{1'b0, 5'd11, 32'd3,        32'd4,        5'd0, 32'd1,         1'b0, 1'b0, 0};
        tbl[5] = '{1'b1, 5'd5,  32'd0,        32'd1,        5'd4, 32'd16,        1'b0, 1'b0, 2};
        tbl[6] = '{1'b0, 5'd0,  32'hF0,       32'h0F,       5'd0, 32'd0,         1'b1, 1'b0, 0};
        tbl[7] = '{1'b1, 5'd7,  32'd0,        32'h80000000, 5'd4, 32'hF8000000,  1'b0, 1'b0, 1};

        do_reset();
        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), !tbl[i].id, tbl[i].id,
                    tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sa,
                    tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sa,
                    tbl[i].stall, tbl[i].id, tbl[i].res, tbl[i].zero, tbl[i].err);

        // contention: both requesters valid continuously from reset
        do_reset();
        req0_valid = 1; req0_op = 5'd1; req0_a = 0; req0_b = 0; req0_sa = 0;
        req1_valid = 1; req1_op = 5'd1; req1_a = 1; req1_b = 0; req1_sa = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                rsp_ids.push_back(int'(rsp_id));
                chk("cont result", rsp_result, {31'd0, rsp_id});
            end
            @(posedge clk);
        end
        #1;
        req0_valid = 0; req1_valid = 0;
        chk("cont grant count", grants.size(), 5);
        chk("cont rsp count", rsp_ids.size(), 4);
        for (int i = 0; i < grants.size(); i++) chk("cont grant order", grants[i], i % 2);
        for (int i = 0; i < rsp_ids.size(); i++) chk("cont rsp order", rsp_ids[i], i % 2);
        repeat (4) @(posedge clk);

        // backpressure with req0 holding a new request throughout
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 5'd2; req0_a = 1; req0_b = 2; rsp_ready = 0;
        @(posedge clk); #1;
        chk("bp exec ready0", req0_ready, 0);
        @(posedge clk); #1;
        chk("bp valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold valid", rsp_valid, 1);
            chk("bp hold result", rsp_result, 3);
            chk("bp hold ready0", req0_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp release valid", rsp_valid, 0);
        chk("bp regrant", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        chk("bp second result", rsp_result, 3);
        @(posedge clk); #1;

        // reset in EXEC abandons the operation and restores prio
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 5'd2; req0_a = 40; req0_b = 2;
        @(posedge clk); #1;
        req0_valid = 0;
        chk("mid exec alu_op", alu_op, 2);
        reset = 1;
        #1;
        chk("mid rst alu_op", alu_op, 0);
        chk("mid rst alu_a", alu_a, 0);
        chk("mid rst valid", rsp_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("mid no response", seen, 0);
        req0_valid = 1; req1_valid = 1; req1_op = 5'd2;
        #1;
        chk("mid prio ready0", req0_ready, 1);
        chk("mid prio ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge clk);

        // randomized transactions against a transaction-level round-robin model
        do_reset();
        prio_m = 0;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(1, 3);
            v0 = r[0]; v1 = r[1];
            o0 = 5'($urandom_range(0, 15)); o1 = 5'($urandom_range(0, 15));
            x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom;
            s0 = 5'($urandom); s1 = 5'($urandom);
            if (t % 4 == 0) begin y0 = x0; y1 = x1; end
            eid  = (v0 && v1) ? prio_m : v1;
            wop  = eid ? o1 : o0;
            ee   = wop >= 5'd12;
            eres = ee ? 32'd0 : (eid ? alu_fn(o1, x1, y1, s1) : alu_fn(o0, x0, y0, s0));
            run_txn($sformatf("rnd%0d", t), v0, v1, o0, x0, y0, s0, o1, x1, y1, s1,
                    $urandom_range(0, 2), eid, eres, !ee && eres == 0, ee);
            prio_m = !eid;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_cpu_alu_arbiter.md
Name: mips_cpu_alu_arbiter

Overview:
Shares one combinational mips_cpu_ALU instance between two requesters: requester 0 is the main execute path, requester 1 is the branch/address helper.
- Accepts one operation at a time over a valid/ready request channel and registers the operands.
- Drives the ALU for exactly one cycle and captures result/zero.
- Returns them, tagged with the requester id, on a single valid/ready response channel.
- Fairness is round-robin. Illegal opcodes are rejected without touching the ALU.

Parameters:
NUM_OPS, 12, opcodes 0..NUM_OPS-1 are legal; op >= NUM_OPS is illegal.
RESET_PRIO, 0, requester that holds priority after reset (0 or 1).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  5  requester 0 ALU opcode
req0_a  in  32  requester 0 operand a
req0_b  in  32  requester 0 operand b
req0_sa  in  5  requester 0 shift amount
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_sa  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accepts
rsp_id  out  1  requester id the response belongs to
rsp_result  out  32  captured ALU result
rsp_zero  out  1  captured ALU zero flag
rsp_err  out  1  1 = illegal opcode; result 0, zero 0
alu_op  out  5  to ALU op
alu_a  out  32  to ALU a
alu_b  out  32  to ALU b
alu_sa  out  5  to ALU sa
alu_result  in  32  from ALU result
alu_zero  in  1  from ALU zero

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (asynchronous) forces:
  - state IDLE; prio = RESET_PRIO.
  - All operand/response registers cleared.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0.
  - alu_* = 0; req0_ready = req1_ready = 0 while reset is asserted.
- A reset asserted mid-operation abandons the in-flight operation. No response is ever produced for it.

IDLE:
- Grant goes to the requester with valid=1. If both are valid, grant goes to the requester equal to prio.
- reqN_ready = 1 combinationally for the granted requester only. The other requester's ready = 0.
- On a handshake (valid & ready), capture op/a/b/sa and the id, set prio = !id, and go to EXEC.
- prio only changes on a handshake.
- If the captured op >= NUM_OPS: set err and go straight to RESP with result 0, zero 0. The ALU is not driven.

EXEC (exactly 1 cycle):
- alu_op/a/b/sa driven from the captured registers.
- At the clock edge: rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_err <= 0, rsp_id <= captured id. Go to RESP.

RESP:
- rsp_valid = 1. rsp_* are held stable until rsp_ready.
- On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops the next cycle.
- No new request is accepted in RESP or EXEC: both readies = 0.

Driving rules:
- alu_* = 0 in IDLE and RESP. Only EXEC drives live operands, so ALU output is sampled only when its inputs are fully defined.

Timing:
- Latency: handshake at edge N, EXEC during cycle N+1, rsp_valid high from N+2.
- Minimum issue interval is 3 cycles per operation when rsp_ready is held at 1.

Other rules:
- Request inputs are sampled only at the handshake edge. Operand changes after acceptance have no effect.
- A requester that drops valid before ready causes no grant and no prio change.
- Arithmetic is pure pass-through. The arbiter performs no width or sign manipulation.

Test Plan:
- Single op: req0 op=2 a=5 b=7 only. Require ready0 at N, rsp_valid at N+2 with rsp_id=0, result=12, zero=0.
- Zero flag: req1 op=3 a=9 b=9. Require rsp_id=1, result=0, zero=1.
- Contention: both requesters valid continuously after reset, each with op=1, a=id, b=0. Grants alternate 0,1,0,1. Responses alternate rsp_id 0,1,0,1, and each result equals its id.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Outputs stay stable, no new grant occurs, and req0_ready stays 0. Release rsp_ready; IDLE grants the next request one cycle later.
- Illegal op: req0 op=12. Require rsp_err=1, result=0, zero=0 at N+1, with alu_* held 0 throughout.
- Reset mid-op: assert reset in EXEC. All outputs clear immediately. After release, no response appears and prio = RESET_PRIO.
